// File: rtl/breath_ramp_gen.sv
// breath_ramp_gen: "breathing LED" ramp controller feeding a downstream PWM generator.
// The compare value ramps up from PULSE_MIN to PERIOD and then back down. It can dwell at
// each end for HOLD_STEPS update intervals. Updates happen once every STEP_CLKS cycles.
//
// Ports:
//   sclk        in   system clock
//   rst         in   asynchronous reset, active high
//   en          in   run enable; low forces IDLE and clears all counters
//   pause       in   freezes tick counter, hold counter, state and pulse
//   period      out  constant PWM period (PERIOD)
//   pulse       out  PWM compare value, always within [PULSE_MIN, PERIOD]
//   state       out  state code: 0 IDLE, 1 RISE, 2 HOLD_HI, 3 FALL, 4 HOLD_LO
//   breath_done out  one-cycle strobe as each complete breath re-enters RISE
module breath_ramp_gen #(
   parameter int unsigned PERIOD     = 1000,
   parameter int unsigned PULSE_MIN  = 1,
   parameter int unsigned STEP       = 1,
   parameter int unsigned STEP_CLKS  = 50_000,
   parameter int unsigned HOLD_STEPS = 100
) (
   input  logic        sclk,
   input  logic        rst,
   input  logic        en,
   input  logic        pause,
   output logic [25:0] period,
   output logic [25:0] pulse,
   output logic [2:0]  state,
   output logic        breath_done
);

   localparam int unsigned TickW = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;
   localparam int unsigned HoldW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

   localparam logic [TickW-1:0]   TickMax   = TickW'(STEP_CLKS - 1);
   localparam logic [HoldW-1:0]   HoldMax   = HoldW'((HOLD_STEPS == 0) ? 0 : HOLD_STEPS - 1);
   localparam logic [25:0]        PeriodVal = 26'(PERIOD);
   localparam logic [25:0]        PulseMin  = 26'(PULSE_MIN);
   localparam logic [26:0]        StepU     = 27'(STEP);
   localparam logic signed [27:0] StepS     = 28'(STEP);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StRise   = 3'd1,
      StHoldHi = 3'd2,
      StFall   = 3'd3,
      StHoldLo = 3'd4
   } state_e;

   state_e             state_q, state_d;
   logic [TickW-1:0]   tick_cnt_q, tick_cnt_d;
   logic [HoldW-1:0]   hold_cnt_q, hold_cnt_d;
   logic [25:0]        pulse_q, pulse_d;
   logic               done_q, done_d;

   logic               tick;
   logic [26:0]        rise_sum;
   logic signed [27:0] fall_diff;
   logic [25:0]        rise_pulse;
   logic [25:0]        fall_pulse;

   // State register
   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         tick_cnt_q <= '0;
         hold_cnt_q <= '0;
         pulse_q    <= PulseMin;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         pulse_q    <= pulse_d;
         done_q     <= done_d;
      end
   end

   // Next-state and datapath
   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      hold_cnt_d = hold_cnt_q;
      pulse_d    = pulse_q;
      done_d     = 1'b0;

      tick       = (tick_cnt_q == TickMax);
      // Extra headroom bit on the way up and a sign bit on the way down make the
      // saturation compares safe for any STEP.
      rise_sum   = {1'b0, pulse_q} + StepU;
      fall_diff  = $signed({2'b00, pulse_q}) - StepS;
      rise_pulse = (rise_sum >= {1'b0, PeriodVal}) ? PeriodVal : rise_sum[25:0];
      fall_pulse = (fall_diff <= $signed({2'b00, PulseMin})) ? PulseMin : fall_diff[25:0];

      // Disable (and any illegal code) wins over pause.
      if (!en || (state_q > StHoldLo)) begin
         state_d    = StIdle;
         tick_cnt_d = '0;
         hold_cnt_d = '0;
         pulse_d    = PulseMin;
      end else if (!pause) begin
         if (state_q != StIdle) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);
         end
         case (state_q)
            StIdle: begin
               state_d    = StRise;
               tick_cnt_d = '0;
               hold_cnt_d = '0;
               pulse_d    = PulseMin;
            end
            StRise: begin
               if (tick) begin
                  pulse_d = rise_pulse;
                  if (rise_pulse == PeriodVal) begin
                     state_d = (HOLD_STEPS == 0) ? StFall : StHoldHi;
                  end
               end
            end
            StHoldHi: begin
               if (tick) begin
                  if (hold_cnt_q == HoldMax) begin
                     hold_cnt_d = '0;
                     state_d    = StFall;
                  end else begin
                     hold_cnt_d = hold_cnt_q + HoldW'(1);
                  end
               end
            end
            StFall: begin
               if (tick) begin
                  pulse_d = fall_pulse;
                  if (fall_pulse == PulseMin) begin
                     if (HOLD_STEPS == 0) begin
                        state_d = StRise;
                        done_d  = 1'b1;
                     end else begin
                        state_d = StHoldLo;
                     end
                  end
               end
            end
            StHoldLo: begin
               if (tick) begin
                  if (hold_cnt_q == HoldMax) begin
                     hold_cnt_d = '0;
                     state_d    = StRise;
                     done_d     = 1'b1;
                  end else begin
                     hold_cnt_d = hold_cnt_q + HoldW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs
   always_comb begin
      period      = PeriodVal;
      pulse       = pulse_q;
      state       = state_q;
      breath_done = done_q;
   end

endmodule

// File: tb/tb_breath_ramp_gen.sv
// Bench for breath_ramp_gen: four instances with different parameter sets share one
// stimulus. A breath-table model predicts every output on every falling edge. Directed
// literal checks pin the expected ramp values.
module tb_breath_ramp_gen;

   logic        sclk  = 1'b0;
   logic        rst   = 1'b0;
   logic        en    = 1'b0;
   logic        pause = 1'b0;
   logic [25:0] period_w [4];
   logic [25:0] pulse_w  [4];
   logic [2:0]  state_w  [4];
   logic        done_w   [4];

   int checks   = 0;
   int failures = 0;
   bit built    = 1'b0;

   // Per-instance parameters, mirrored for the model
   int p_period [4] = '{10, 10, 10, 5};
   int p_min    [4] = '{1, 1, 1, 5};
   int p_step   [4] = '{3, 4, 3, 2};
   int p_sclks  [4] = '{4, 4, 4, 1};
   int p_hold   [4] = '{2, 2, 0, 1};

   // (state, pulse) after k ticks of a breath; entry tbl_len equals entry 0
   int tbl_st  [4][64];
   int tbl_pu  [4][64];
   int tbl_len [4];

   // Model: whether the ramp is running and how many running cycles have passed
   logic m_active = 1'b0;
   int   m_c      = 0;
   logic m_ran    = 1'b0;

   always #5 sclk = ~sclk;

   breath_ramp_gen #(.PERIOD(10), .PULSE_MIN(1), .STEP(3), .STEP_CLKS(4), .HOLD_STEPS(2)) u_a (
      .sclk(sclk), .rst(rst), .en(en), .pause(pause), .period(period_w[0]),
      .pulse(pulse_w[0]), .state(state_w[0]), .breath_done(done_w[0]));
   breath_ramp_gen #(.PERIOD(10), .PULSE_MIN(1), .STEP(4), .STEP_CLKS(4), .HOLD_STEPS(2)) u_b (
      .sclk(sclk), .rst(rst), .en(en), .pause(pause), .period(period_w[1]),
      .pulse(pulse_w[1]), .state(state_w[1]), .breath_done(done_w[1]));
   breath_ramp_gen #(.PERIOD(10), .PULSE_MIN(1), .STEP(3), .STEP_CLKS(4), .HOLD_STEPS(0)) u_c (
      .sclk(sclk), .rst(rst), .en(en), .pause(pause), .period(period_w[2]),
      .pulse(pulse_w[2]), .state(state_w[2]), .breath_done(done_w[2]));
   breath_ramp_gen #(.PERIOD(5), .PULSE_MIN(5), .STEP(2), .STEP_CLKS(1), .HOLD_STEPS(1)) u_d (
      .sclk(sclk), .rst(rst), .en(en), .pause(pause), .period(period_w[3]),
      .pulse(pulse_w[3]), .state(state_w[3]), .breath_done(done_w[3]));

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void build(input int d);
      int pp;
      int pm;
      int s;
      int h;
      int p;
      int n;
      pp = p_period[d];
      pm = p_min[d];
      s  = p_step[d];
      h  = p_hold[d];
      tbl_st[d][0] = 1;
      tbl_pu[d][0] = pm;
      n = 1;
      p = pm;
      do begin
         p = (p + s > pp) ? pp : p + s;
         tbl_st[d][n] = (p == pp) ? ((h > 0) ? 2 : 3) : 1;
         tbl_pu[d][n] = p;
         n++;
      end while (p != pp);
      for (int i = 1; i <= h; i++) begin
         tbl_st[d][n] = (i == h) ? 3 : 2;
         tbl_pu[d][n] = pp;
         n++;
      end
      do begin
         p = (p - s < pm) ? pm : p - s;
         tbl_st[d][n] = (p == pm) ? ((h > 0) ? 4 : 1) : 3;
         tbl_pu[d][n] = p;
         n++;
      end while (p != pm);
      for (int i = 1; i <= h; i++) begin
         tbl_st[d][n] = (i == h) ? 1 : 4;
         tbl_pu[d][n] = pm;
         n++;
      end
      tbl_len[d] = n - 1;
   endfunction

   function automatic int exp_state(input int d);
      if (!m_active) return 0;
      return tbl_st[d][(m_c / p_sclks[d]) % tbl_len[d]];
   endfunction

   function automatic int exp_pulse(input int d);
      if (!m_active) return p_min[d];
      return tbl_pu[d][(m_c / p_sclks[d]) % tbl_len[d]];
   endfunction

   function automatic int exp_done(input int d);
      if (!m_ran || m_c == 0 || (m_c % p_sclks[d]) != 0) return 0;
      return (((m_c / p_sclks[d]) % tbl_len[d]) == 0) ? 1 : 0;
   endfunction

   always @(posedge sclk or posedge rst) begin
      if (rst || !en) begin
         m_active <= 1'b0;
         m_c      <= 0;
         m_ran    <= 1'b0;
      end else if (pause) begin
         m_ran <= 1'b0;
      end else if (!m_active) begin
         m_active <= 1'b1;
         m_c      <= 0;
         m_ran    <= 1'b0;
      end else begin
         m_c   <= m_c + 1;
         m_ran <= 1'b1;
      end
   end

   always @(negedge sclk) begin
      if (built) begin
         for (int d = 0; d < 4; d++) begin
            chk($sformatf("d%0d.period", d), int'(period_w[d]), p_period[d]);
            chk($sformatf("d%0d.state", d), int'(state_w[d]), exp_state(d));
            chk($sformatf("d%0d.pulse", d), int'(pulse_w[d]), exp_pulse(d));
            chk($sformatf("d%0d.done", d), int'(done_w[d]), exp_done(d));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge sclk);
      #1;
   endtask

   initial begin
      for (int d = 0; d < 4; d++) build(d);
      built = 1'b1;
      chk("model.len_a", tbl_len[0], 10);
      chk("model.len_c", tbl_len[2], 6);
      chk("model.len_d", tbl_len[3], 4);

      #1 rst = 1'b1;
      step(3);
      chk("rst.state", int'(state_w[0]), 0);
      chk("rst.pulse", int'(pulse_w[0]), 1);
      chk("rst.period", int'(period_w[0]), 10);
      chk("rst.done", int'(done_w[0]), 0);
      rst = 1'b0;
      step(2);
      chk("idle.state", int'(state_w[0]), 0);

      // First breath
      en = 1'b1;
      step(1);
      chk("rise.entry", int'(state_w[0]), 1);
      chk("rise.p0", int'(pulse_w[0]), 1);
      step(3);
      chk("rise.no_early", int'(pulse_w[0]), 1);
      step(1);
      chk("rise.a1", int'(pulse_w[0]), 4);
      chk("rise.b1", int'(pulse_w[1]), 5);
      step(4);
      chk("rise.a2", int'(pulse_w[0]), 7);
      chk("rise.b2", int'(pulse_w[1]), 9);
      step(4);
      chk("rise.a3", int'(pulse_w[0]), 10);
      chk("hold_hi.a", int'(state_w[0]), 2);
      chk("rise.b3_sat", int'(pulse_w[1]), 10);
      chk("nohold.c_fall", int'(state_w[2]), 3);
      step(8);
      chk("fall.entry_a", int'(state_w[0]), 3);
      chk("fall.entry_pa", int'(pulse_w[0]), 10);
      step(4);
      chk("fall.a1", int'(pulse_w[0]), 7);
      chk("fall.b1", int'(pulse_w[1]), 6);
      chk("nohold.c_rise", int'(state_w[2]), 1);
      chk("nohold.c_pulse", int'(pulse_w[2]), 1);
      chk("nohold.c_done", int'(done_w[2]), 1);
      step(4);
      chk("fall.a2", int'(pulse_w[0]), 4);
      chk("fall.b2", int'(pulse_w[1]), 2);
      step(4);
      chk("fall.a3", int'(pulse_w[0]), 1);
      chk("fall.b3_sat", int'(pulse_w[1]), 1);
      chk("hold_lo.a", int'(state_w[0]), 4);
      step(7);
      chk("hold_lo.a_late", int'(state_w[0]), 4);
      chk("hold_lo.no_done", int'(done_w[0]), 0);
      step(1);
      chk("breath.a_rise", int'(state_w[0]), 1);
      chk("breath.a_done", int'(done_w[0]), 1);
      chk("breath.b_done", int'(done_w[1]), 1);
      step(1);
      chk("breath.done_1cyc", int'(done_w[0]), 0);

      // Pause mid-RISE with pulse=4, two cycles into the interval
      step(3);
      chk("pause.pre", int'(pulse_w[0]), 4);
      step(2);
      pause = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(1);
         chk("pause.pulse", int'(pulse_w[0]), 4);
         chk("pause.state", int'(state_w[0]), 1);
      end
      pause = 1'b0;
      step(1);
      chk("resume.wait", int'(pulse_w[0]), 4);
      step(1);
      chk("resume.update", int'(pulse_w[0]), 7);

      // Disable in HOLD_HI, with pause also raised
      step(4);
      chk("dis.pre_state", int'(state_w[0]), 2);
      en    = 1'b0;
      pause = 1'b1;
      step(1);
      chk("dis.state", int'(state_w[0]), 0);
      chk("dis.pulse", int'(pulse_w[0]), 1);
      chk("dis.done", int'(done_w[0]), 0);
      pause = 1'b0;
      step(2);

      // Asynchronous reset mid-FALL
      en = 1'b1;
      step(1);
      chk("re.entry", int'(state_w[0]), 1);
      step(24);
      chk("mid_fall.state", int'(state_w[0]), 3);
      chk("mid_fall.pulse", int'(pulse_w[0]), 7);
      #2 rst = 1'b1;
      #1;
      chk("arst.state", int'(state_w[0]), 0);
      chk("arst.pulse", int'(pulse_w[0]), 1);
      chk("arst.done", int'(done_w[0]), 0);
      step(2);
      rst = 1'b0;
      step(1);
      chk("post_rst.rise", int'(state_w[0]), 1);

      step(60);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/breath_ramp_gen.md
BREATH_RAMP_GEN -- requirements
Module: breath_ramp_gen

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Parameter PERIOD, default 1000: PWM count period driven on `period`; legal range 1..50_000_000.
REQ-003 Parameter PULSE_MIN, default 1: lowest compare value; legal range 1..PERIOD.
REQ-004 Parameter STEP, default 1: pulse increment/decrement per update; legal range >=1.
REQ-005 Parameter STEP_CLKS, default 50_000: sclk cycles between updates; legal range >=1.
REQ-006 Parameter HOLD_STEPS, default 100: update intervals spent in each hold state; 0 means no hold.
REQ-007 sclk  in  1  system clock.
REQ-008 rst  in  1  asynchronous reset, active high.
REQ-009 en  in  1  run enable, level sensitive.
REQ-010 pause  in  1  freeze ramp, level sensitive.
REQ-011 period  out  26  PWM period for the downstream PWM generator.
REQ-012 pulse  out  26  PWM compare value for the downstream PWM generator, always within [PULSE_MIN, PERIOD].
REQ-013 state  out  3  current state code.
REQ-014 breath_done  out  1  one-cycle strobe at the end of each full breath.

Function
REQ-015 period SHALL be the constant PERIOD at all times, including during reset.
REQ-016 The tick counter SHALL count 0..STEP_CLKS-1 while the state is not IDLE and pause=0, and SHALL wrap to 0.
REQ-017 tick SHALL be high for exactly one cycle when the counter equals STEP_CLKS-1; with STEP_CLKS=1, tick SHALL be high on every running cycle.
REQ-018 States and encodings SHALL be: IDLE=0, RISE=1, HOLD_HI=2, FALL=3, HOLD_LO=4; codes 5-7 SHALL return to IDLE on the next edge.
REQ-019 In IDLE, pulse SHALL equal PULSE_MIN, and the tick and hold counters SHALL be cleared.
REQ-020 In IDLE with en=1, the block SHALL enter RISE on the next edge.
REQ-021 In RISE, on each tick, pulse SHALL become min(pulse+STEP, PERIOD); the sum SHALL be computed 27 bits wide so it cannot overflow.
REQ-022 When a RISE update yields PERIOD, the same edge SHALL move to HOLD_HI, or to FALL if HOLD_STEPS=0.
REQ-023 In HOLD_HI, pulse SHALL hold, and each tick SHALL increment the hold counter.
REQ-024 HOLD_HI SHALL move to FALL on the tick where the hold counter equals HOLD_STEPS-1, and the hold counter SHALL be cleared.
REQ-025 In FALL, on each tick, pulse SHALL become max(pulse-STEP, PULSE_MIN), computed signed so it cannot underflow.
REQ-026 When a FALL update reaches PULSE_MIN, the same edge SHALL move to HOLD_LO, or to RISE if HOLD_STEPS=0.
REQ-027 HOLD_LO SHALL move to RISE after HOLD_STEPS ticks, following the same counting as HOLD_HI.
REQ-028 breath_done SHALL pulse high for one cycle on every transition from HOLD_LO to RISE, or from FALL to RISE when HOLD_STEPS=0.
REQ-029 If PULSE_MIN=PERIOD, RISE and FALL SHALL each complete in one tick with pulse unchanged.
REQ-030 pulse SHALL change only on a tick edge or on entry to IDLE; successive changes SHALL be at least STEP_CLKS cycles apart.
REQ-031 en=0 in any state SHALL force IDLE on the next edge, set pulse to PULSE_MIN and clear all counters, without asserting breath_done.
REQ-032 While pause=1, the tick counter, hold counter, state and pulse SHALL all freeze.
REQ-033 en=0 SHALL take priority over pause.
REQ-034 Deasserting pause SHALL resume counting from the frozen tick count.

Reset
REQ-035 While rst=1, the block SHALL hold: state=IDLE, pulse=PULSE_MIN, period=PERIOD, breath_done=0, and all counters at 0.
REQ-036 Reset asserted mid-ramp SHALL take effect immediately (asynchronously).
REQ-037 The first edge after rst falls with en=1 SHALL enter RISE.

Verification
REQ-038 Parameters PERIOD=10, PULSE_MIN=1, STEP=3, STEP_CLKS=4, HOLD_STEPS=2, en raised after reset:
- state=1 one edge later;
- pulse steps 1->4->7->10 on edges spaced 4 cycles apart;
- state becomes 2 on the edge where pulse=10.
REQ-039 Same run continued:
- state=3 after 2 further ticks (8 cycles);
- pulse steps 10->7->4->1;
- state=4, then after 2 ticks state=1 with breath_done high for exactly 1 cycle;
- full breath = 10 ticks = 40 cycles.
REQ-040 STEP=4, PERIOD=10: pulse SHALL step 1->5->9->10 (saturated), then 10->6->2->1 (saturated at PULSE_MIN).
REQ-041 pause=1 held for 20 cycles mid-RISE with pulse=4:
- pulse stays 4 and state stays 1 throughout;
- after release, the next update lands exactly at the remaining tick count.
REQ-042 Interrupts:
- en dropped in HOLD_HI -> next edge state=0, pulse=1, breath_done=0;
- rst pulsed mid-FALL -> outputs at reset values immediately, without waiting for a clock edge.
REQ-043 HOLD_STEPS=0: RISE goes directly to FALL at pulse=10, FALL goes directly to RISE at pulse=1, and breath_done pulses on each FALL->RISE transition.
